// File: rtl/usb_phy_pkg.sv
// Shared types and constants for the USB PHY power/rate controller.
package usb_phy_pkg;

  localparam int unsigned PWR_W = 2;

  localparam logic [PWR_W-1:0] P0 = 2'b00;
  localparam logic [PWR_W-1:0] P1 = 2'b01;
  localparam logic [PWR_W-1:0] P2 = 2'b10;
  localparam logic [PWR_W-1:0] P3 = 2'b11;

  typedef enum logic [2:0] {
    RST_WAIT = 3'd0,
    IDLE     = 3'd1,
    APPLY    = 3'd2,
    SETTLE   = 3'd3,
    ACK      = 3'd4
  } pwr_fsm_e;

endpackage

// File: rtl/usb_settle_timer.sv
// Loadable down-counter; done_o is high while the count is at or below one.
module usb_settle_timer #(
  parameter int unsigned W = 7
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         done_o
);

  logic [W-1:0] count_q, count_d;
  logic         done_q, done_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != W'(0))) begin
      count_d = count_q - W'(1);
    end
    done_d = (count_d <= W'(1));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      done_q  <= 1'b1;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/usb_power_ctrl.sv
// PIPE power-state / rate sequencer: applies MAC requests, waits a settle
// time, and reports completion on PHYSTATUS.
module usb_power_ctrl #(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned P3_EXIT_CYCLES = 64
) (
  input  logic       DATA_CLK_125,
  input  logic       DATA_RST,
  input  logic [1:0] POWERDOWN_REQ,
  input  logic       RATE_REQ,
  input  logic       TXELECIDLE_REQ,
  output logic [1:0] DATA_POWER,
  output logic       DATA_RATE,
  output logic       TXELECIDLE,
  output logic       PHYSTATUS,
  output logic       BUSY,
  output logic       RATE_ERR
);

  import usb_phy_pkg::*;

  localparam int unsigned SETTLE_MAX = (SETTLE_CYCLES > P3_EXIT_CYCLES) ?
                                       SETTLE_CYCLES : P3_EXIT_CYCLES;
  localparam int unsigned CNT_W      = (SETTLE_MAX < 1) ? 1 : $clog2(SETTLE_MAX + 1);

  pwr_fsm_e         state_q, state_d;
  logic [PWR_W-1:0] power_q, power_d;
  logic             rate_q, rate_d;
  logic             txei_q, txei_d;
  logic             phystatus_q, phystatus_d;
  logic             busy_q, busy_d;
  logic             rate_err_q, rate_err_d;
  logic             is_rate_q, is_rate_d;
  logic             from_p3_q, from_p3_d;
  logic             err_blk_q, err_blk_d;
  logic [CNT_W-1:0] rst_cnt_q, rst_cnt_d;

  logic             load_c;
  logic             dec_c;
  logic [CNT_W-1:0] load_val_c;
  logic             timer_done;

  assign load_val_c = from_p3_q ? CNT_W'(P3_EXIT_CYCLES) : CNT_W'(SETTLE_CYCLES);

  usb_settle_timer #(.W(CNT_W)) u_settle_timer (
    .clk_i      (DATA_CLK_125),
    .rst_ni     (DATA_RST),
    .load_i     (load_c),
    .load_val_i (load_val_c),
    .dec_i      (dec_c),
    .done_o     (timer_done)
  );

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_comb begin
    state_d    = state_q;
    power_d    = power_q;
    rate_d     = rate_q;
    is_rate_d  = is_rate_q;
    from_p3_d  = from_p3_q;
    err_blk_d  = err_blk_q;
    rst_cnt_d  = rst_cnt_q;
    rate_err_d = 1'b0;
    load_c     = 1'b0;
    dec_c      = 1'b0;

    unique case (state_q)
      RST_WAIT: begin
        if (32'(rst_cnt_q) + 32'd1 >= SETTLE_CYCLES) begin
          state_d = IDLE;
        end else begin
          rst_cnt_d = rst_cnt_q + CNT_W'(1);
        end
      end
      IDLE: begin
        if (POWERDOWN_REQ != power_q) begin
          power_d   = POWERDOWN_REQ;
          from_p3_d = (power_q == P3);
          is_rate_d = 1'b0;
          state_d   = APPLY;
        end else if (RATE_REQ != rate_q) begin
          if ((power_q == P0) && TXELECIDLE_REQ) begin
            rate_d    = RATE_REQ;
            from_p3_d = 1'b0;
            is_rate_d = 1'b1;
            err_blk_d = 1'b0;
            state_d   = APPLY;
          end else if (!err_blk_q) begin
            // One error pulse per distinct rejected request.
            rate_err_d = 1'b1;
            err_blk_d  = 1'b1;
          end
        end else begin
          err_blk_d = 1'b0;
        end
      end
      APPLY: begin
        load_c  = 1'b1;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (timer_done) begin
          state_d = ACK;
        end else begin
          dec_c = 1'b1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = RST_WAIT;
      end
    endcase

    phystatus_d = (state_d == RST_WAIT) || (state_d == ACK);
    busy_d      = (state_d != IDLE);
    txei_d      = TXELECIDLE_REQ | power_d[1] |
                  (is_rate_d && ((state_d == APPLY) || (state_d == SETTLE)));
  end

  always_ff @(posedge DATA_CLK_125 or negedge DATA_RST) begin
    if (!DATA_RST) begin
      state_q     <= RST_WAIT;
      power_q     <= P2;
      rate_q      <= 1'b0;
      txei_q      <= 1'b1;
      phystatus_q <= 1'b1;
      busy_q      <= 1'b1;
      rate_err_q  <= 1'b0;
      is_rate_q   <= 1'b0;
      from_p3_q   <= 1'b0;
      err_blk_q   <= 1'b0;
      rst_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      power_q     <= power_d;
      rate_q      <= rate_d;
      txei_q      <= txei_d;
      phystatus_q <= phystatus_d;
      busy_q      <= busy_d;
      rate_err_q  <= rate_err_d;
      is_rate_q   <= is_rate_d;
      from_p3_q   <= from_p3_d;
      err_blk_q   <= err_blk_d;
      rst_cnt_q   <= rst_cnt_d;
    end
  end

  assign DATA_POWER = power_q;
  assign DATA_RATE  = rate_q;
  assign TXELECIDLE = txei_q;
  assign PHYSTATUS  = phystatus_q;
  assign BUSY       = busy_q;
  assign RATE_ERR   = rate_err_q;

endmodule
